// File: rtl/bs_fetch_loader_pkg.sv
// Shared types and helpers for the bitstream fetch loader.
// The optional byte-swap build is selected by BS_FETCH_BYTE_SWAP_EN.
package bs_fetch_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_READY = 3'd4
  } state_t;

  // Upper bound for MAX_OUTST; sizes the outstanding-read counter.
  localparam int unsigned MAX_OUTST_CEIL = 8;

  function automatic logic [31:0] byte_swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/bs_fetch_ram.sv
// Simple dual-port RAM, 2^DEPTH_LOG2 x 32: one write port, one registered
// read-first read port. Halfword selection is done by the parent.
module bs_fetch_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  ren,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [0:(1 << DEPTH_LOG2) - 1];
  logic [31:0] rdata_r;

  // Storage array write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; sees the pre-write value on a same-word collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (ren) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/bs_fetch_loader.sv
// Bitstream loader: DMA-fetches a frame's byte range into local RAM, then serves
// the decoder's halfword reads. Define BS_FETCH_BYTE_SWAP_EN for little-endian memory.
module bs_fetch_loader
  import bs_fetch_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [31:0] buf_base_i,
  input  logic [31:0] buf_end_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        mem_req_start,
  input  logic        BitStream_ram_ren,
  input  logic [16:0] BitStream_ram_addr,
  output logic [15:0] BitStream_buffer_input,
  input  logic        end_of_one_frame,
  output logic        busy_o,
  output logic        err_o,
  output logic [7:0]  frame_cnt_o
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int OW = $clog2(MAX_OUTST_CEIL + 1);
  localparam logic [32:0]   DEPTH_WORDS = 33'd1 << DEPTH_LOG2;
  localparam logic [OW-1:0] OUTST_LIM   = OW'(MAX_OUTST);
  localparam logic [OW-1:0] OW_ONE      = OW'(1);
  localparam logic [CW-1:0] CW_ONE      = CW'(1);

  state_t          state_r, state_s;
  logic [29:0]     base_r;
  logic [32:0]     len_r;
  logic            range_bad_r;
  logic [CW-1:0]   issued_r, rcvd_r;
  logic [OW-1:0]   outst_r;
  logic            err_r, start_pulse_r, rd_sel_r, go_ready_s;
  logic [7:0]      frame_cnt_r;
  logic [31:0]     base_al_s, wdata_s, ram_rdata_s;
  logic [32:0]     len_calc_s;
  logic [CW-1:0]   len_cw_s;
  logic            start_ok_s, bus_req_s, grant_s, accept_s, rd_s, check_bad_s;
  logic            unused_base_s;

  assign unused_base_s = ^buf_base_i[1:0];

  generate
    if (DEPTH_LOG2 < 16) begin : g_alias
      logic unused_addr_hi_s;
      assign unused_addr_hi_s = ^BitStream_ram_addr[16:DEPTH_LOG2+1];
    end
  endgenerate

  assign base_al_s   = {buf_base_i[31:2], 2'b00};
  assign len_calc_s  = ({1'b0, buf_end_i} - {1'b0, base_al_s} + 33'd3) >> 2;
  assign len_cw_s    = len_r[CW-1:0];
  assign start_ok_s  = start_i && ((state_r == ST_IDLE) || (state_r == ST_READY));
  assign check_bad_s = range_bad_r || (len_r > DEPTH_WORDS);
  assign bus_req_s   = (state_r == ST_FETCH) && (issued_r < len_cw_s) && (outst_r < OUTST_LIM);
  assign grant_s     = bus_req_s && bus_gnt_i;
  // Returns are only counted while a fetch is live; strays (e.g. after reset) are dropped.
  assign accept_s    = bus_rvalid_i && ((state_r == ST_FETCH) || (state_r == ST_DRAIN))
                       && (outst_r != {OW{1'b0}});
  assign rd_s        = !BitStream_ram_ren;

`ifdef BS_FETCH_BYTE_SWAP_EN
  assign wdata_s = byte_swap32(bus_rdata_i);
`else
  assign wdata_s = bus_rdata_i;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and ready-pulse request.
  always_comb begin
    state_s    = state_r;
    go_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:  if (start_i) state_s = ST_CHECK; else state_s = ST_IDLE;
      ST_CHECK: if (check_bad_s) state_s = ST_IDLE; else state_s = ST_FETCH;
      ST_FETCH: if (issued_r == len_cw_s) state_s = ST_DRAIN; else state_s = ST_FETCH;
      ST_DRAIN: begin
        if (rcvd_r == len_cw_s) begin
          state_s    = ST_READY;
          go_ready_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_READY: if (start_i) state_s = ST_CHECK; else state_s = ST_READY;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Transfer bookkeeping: captured range, counters, error flag and ready pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r        <= 30'd0;
      len_r         <= 33'd0;
      range_bad_r   <= 1'b0;
      issued_r      <= {CW{1'b0}};
      rcvd_r        <= {CW{1'b0}};
      outst_r       <= {OW{1'b0}};
      err_r         <= 1'b0;
      start_pulse_r <= 1'b0;
    end else begin
      start_pulse_r <= go_ready_s;
      if (start_ok_s) begin
        base_r      <= buf_base_i[31:2];
        len_r       <= len_calc_s;
        range_bad_r <= (buf_end_i <= base_al_s);
        issued_r    <= {CW{1'b0}};
        rcvd_r      <= {CW{1'b0}};
        outst_r     <= {OW{1'b0}};
        err_r       <= 1'b0;
      end else begin
        if ((state_r == ST_CHECK) && check_bad_s) begin
          err_r <= 1'b1;
        end
        if (grant_s) begin
          issued_r <= issued_r + CW_ONE;
        end
        if (accept_s) begin
          rcvd_r <= rcvd_r + CW_ONE;
        end
        if (grant_s && !accept_s) begin
          outst_r <= outst_r + OW_ONE;
        end else if (!grant_s && accept_s) begin
          outst_r <= outst_r - OW_ONE;
        end
      end
    end
  end

  // Decoder frame counter, free-running across all states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_r <= 8'd0;
    end else if (end_of_one_frame) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end
  end

  // Halfword select travels with the registered RAM read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel_r <= 1'b0;
    end else if (rd_s) begin
      rd_sel_r <= BitStream_ram_addr[0];
    end
  end

  bs_fetch_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wen     (accept_s),
    .waddr   (rcvd_r[DEPTH_LOG2-1:0]),
    .wdata   (wdata_s),
    .ren     (rd_s),
    .raddr   (BitStream_ram_addr[DEPTH_LOG2:1]),
    .rdata   (ram_rdata_s)
  );

  assign bus_req_o              = bus_req_s;
  assign bus_addr_o             = {base_r + {{(30-CW){1'b0}}, issued_r}, 2'b00};
  assign mem_req_start          = start_pulse_r;
  assign BitStream_buffer_input = rd_sel_r ? ram_rdata_s[15:0] : ram_rdata_s[31:16];
  assign busy_o                 = (state_r == ST_CHECK) || (state_r == ST_FETCH) || (state_r == ST_DRAIN);
  assign err_o                  = err_r;
  assign frame_cnt_o            = frame_cnt_r;

endmodule

// File: tb/tb_bs_fetch_loader.sv
// Scoreboard bench for bs_fetch_loader (DEPTH_LOG2=4): randomized loads and reads
// checked against a word-level reference model of system memory and local RAM.
module tb_bs_fetch_loader;

  localparam int DL   = 4;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] buf_base_i = 32'h0, buf_end_i = 32'h0;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        mem_req_start;
  logic        BitStream_ram_ren = 1'b1;
  logic [16:0] BitStream_ram_addr = 17'h0;
  logic [15:0] BitStream_buffer_input;
  logic        end_of_one_frame = 1'b0;
  logic        busy_o, err_o;
  logic [7:0]  frame_cnt_o;

  bs_fetch_loader #(.DEPTH_LOG2(DL), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .buf_base_i(buf_base_i),
    .buf_end_i(buf_end_i), .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .mem_req_start(mem_req_start), .BitStream_ram_ren(BitStream_ram_ren),
    .BitStream_ram_addr(BitStream_ram_addr), .BitStream_buffer_input(BitStream_buffer_input),
    .end_of_one_frame(end_of_one_frame), .busy_o(busy_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_addr_q[$];
  int          exp_start_q[$];
  logic [15:0] exp_rd_q[$];
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];
  logic [31:0] ram_model [0:(1<<DL)-1];
  logic [31:0] sysmem [int unsigned];
  int lat = 2, cyc = 0, tb_outst = 0, grants = 0, starts_seen = 0, first_rv_grants = 0;
  bit gnt_rand = 1'b0, spur_en = 1'b1, rv_seen = 1'b0, rd_pend = 1'b0;
  int fc_mode = 1;
  logic [7:0] exp_fc = 8'd0;

  function automatic logic [31:0] sys_word(input logic [31:0] a);
    if (sysmem.exists(a)) return sysmem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ram_img(input logic [31:0] d);
`ifdef BS_FETCH_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus slave: in-order returns after 'lat' cycles, optional random grant, stray rvalids.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = sys_word(pend_addr_q[0]);
      void'(pend_addr_q.pop_front());
      void'(pend_due_q.pop_front());
    end else begin
      bus_rvalid_i = spur_en && (pend_due_q.size() == 0) && ($urandom_range(0, 5) == 0);
      bus_rdata_i  = $urandom;
    end
    bus_gnt_i        = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end_of_one_frame = (fc_mode == 2) ? 1'b1 : ((fc_mode == 1) && ($urandom_range(0, 3) == 0));
  end

  // Monitor: pops expectations whenever the DUT presents a request, pulse or read data.
  always @(negedge clk) begin
    if (!reset_n) begin
      tb_outst = 0;
      exp_fc   = 8'd0;
      rd_pend  = 1'b0;
    end else begin
      chk("frame_cnt", {24'h0, frame_cnt_o}, {24'h0, exp_fc});
      if (end_of_one_frame) exp_fc = exp_fc + 8'd1;
      if (bus_rvalid_i && tb_outst > 0) begin
        tb_outst--;
        if (!rv_seen) begin
          rv_seen = 1'b1;
          first_rv_grants = grants;
        end
      end
      if (bus_req_o && bus_gnt_i) begin
        grants++;
        tb_outst++;
        if (exp_addr_q.size() == 0) chk("unexpected_req", bus_addr_o, 32'hFFFF_FFFF);
        else chk("bus_addr", bus_addr_o, exp_addr_q.pop_front());
        pend_addr_q.push_back(bus_addr_o);
        pend_due_q.push_back(cyc + lat);
        chk("outst_le_max", {31'h0, (tb_outst <= MAXO)}, 32'h1);
      end
      if (mem_req_start) begin
        starts_seen++;
        if (exp_start_q.size() == 0) chk("unexpected_mem_req_start", 32'h1, 32'h0);
        else chk("mem_req_start", 32'h1, 32'(exp_start_q.pop_front()));
      end
      if (rd_pend) begin
        if (exp_rd_q.size() == 0) chk("unexpected_read", {16'h0, BitStream_buffer_input}, 32'hFFFF_FFFF);
        else chk("read_data", {16'h0, BitStream_buffer_input}, {16'h0, exp_rd_q.pop_front()});
      end
      rd_pend = !BitStream_ram_ren;
    end
  end

  task automatic load(input logic [31:0] base, input logic [31:0] endb);
    logic [31:0] bal;
    longint unsigned ln;
    bit bad, seen;
    int s0;
    bal = {base[31:2], 2'b00};
    ln  = ({32'h0, endb} - {32'h0, bal} + 64'd3) >> 2;
    bad = (endb <= bal) || (ln > (64'd1 << DL));
    if (!bad) begin
      for (longint unsigned i = 0; i < ln; i++) exp_addr_q.push_back(bal + 32'(4 * i));
      exp_start_q.push_back(1);
    end
    s0 = starts_seen;
    rv_seen = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; buf_base_i = base; buf_end_i = endb;
    @(posedge clk); #1;
    start_i = 1'b0; buf_base_i = $urandom; buf_end_i = $urandom;
    chk("busy_in_check", {31'h0, busy_o}, 32'h1);
    if (bad) begin
      @(posedge clk); #1;
      chk("err_set", {31'h0, err_o}, 32'h1);
      chk("busy_after_err", {31'h0, busy_o}, 32'h0);
      repeat (3) @(posedge clk);
    end else begin
      seen = 1'b0;
      for (int t = 0; t < 400 && !seen; t++) begin
        @(negedge clk); #1;
        seen = (starts_seen != s0);
      end
      if (!seen) begin
        chk("load_timeout", 32'h0, 32'h1);
        exp_addr_q.delete();
        exp_start_q.delete();
      end
      @(negedge clk); #1;
      chk("busy_done", {31'h0, busy_o}, 32'h0);
      chk("err_clear", {31'h0, err_o}, 32'h0);
      chk("all_addr_issued", exp_addr_q.size(), 32'h0);
      for (longint unsigned i = 0; i < ln; i++) ram_model[i] = ram_img(sys_word(bal + 32'(4 * i)));
    end
  endtask

  task automatic rd_exp(input logic [16:0] a, input logic [15:0] e);
    @(posedge clk); #1;
    BitStream_ram_ren = 1'b0; BitStream_ram_addr = a;
    exp_rd_q.push_back(e);
    @(posedge clk); #1;
    BitStream_ram_ren = 1'b1; BitStream_ram_addr = 17'($urandom);
  endtask

  function automatic logic [15:0] model_half(input logic [16:0] a);
    logic [31:0] w;
    w = ram_model[a[DL:1]];
    return a[0] ? w[15:0] : w[31:16];
  endfunction

  task automatic rand_reads(input int n);
    logic [16:0] a;
    logic [15:0] last;
    last = 16'h0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        BitStream_ram_ren = 1'b1; BitStream_ram_addr = 17'($urandom);
      end else begin
        a = 17'($urandom);
        BitStream_ram_ren = 1'b0; BitStream_ram_addr = a;
        last = model_half(a);
        exp_rd_q.push_back(last);
      end
    end
    @(posedge clk); #1;
    BitStream_ram_ren = 1'b1; BitStream_ram_addr = 17'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (n > 0) chk("read_hold", {16'h0, BitStream_buffer_input}, {16'h0, last});
  endtask

  initial begin
    int g0;
    bit hit;
    sysmem[32'h1000] = 32'hAABB_CCDD;
    sysmem[32'h3000] = 32'h1122_3344;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_mem_req_start", {31'h0, mem_req_start}, 32'h0);
    chk("rst_rd_data", {16'h0, BitStream_buffer_input}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_frame_cnt", {24'h0, frame_cnt_o}, 32'h0);
    #2 reset_n = 1'b1;

    // Basic 4-word load.
    g0 = grants;
    load(32'h1000, 32'h1010);
    chk("four_grants", grants - g0, 32'd4);
`ifdef BS_FETCH_BYTE_SWAP_EN
    rd_exp(17'h0, 16'hDDCC); rd_exp(17'h1, 16'hBBAA);
`else
    rd_exp(17'h0, 16'hAABB); rd_exp(17'h1, 16'hCCDD);
`endif
    // Single word, endian check.
    load(32'h3000, 32'h3004);
`ifdef BS_FETCH_BYTE_SWAP_EN
    rd_exp(17'h0, 16'h4433); rd_exp(17'h1, 16'h2211);
`else
    rd_exp(17'h0, 16'h1122); rd_exp(17'h1, 16'h3344);
`endif
    // Long latency: outstanding cap.
    spur_en = 1'b0; lat = 20;
    g0 = grants;
    load(32'h4000, 32'h4040);
    chk("grants_before_first_rvalid", first_rv_grants - g0, 32'd4);
    rand_reads(10);
    spur_en = 1'b1; lat = 2;
    // Range errors and capacity boundary.
    load(32'h2000, 32'h2000);
    load(32'h5000, 32'h5044);
    load(32'h5000, 32'h5040);
    rand_reads(12);
    load(32'h6002, 32'h6007);
    rand_reads(6);

    // Reset in the middle of a fetch.
    fc_mode = 0; lat = 8;
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(32'h7000 + 32'(4 * i));
    g0 = grants;
    @(posedge clk); #1;
    start_i = 1'b1; buf_base_i = 32'h7000; buf_end_i = 32'h7020;
    @(posedge clk); #1;
    start_i = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge clk); #1;
      hit = (grants - g0 >= 2);
    end
    chk("reset_grants_reached", {31'h0, hit}, 32'h1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("req_drops_on_reset", {31'h0, bus_req_o}, 32'h0);
    chk("busy_drops_on_reset", {31'h0, busy_o}, 32'h0);
    exp_addr_q.delete();
    exp_start_q.delete();
    @(negedge clk); @(negedge clk); #2;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    rand_reads(10);
    lat = 3; fc_mode = 1;
    load(32'h7000, 32'h7020);
    rand_reads(10);

    // Randomized loads with random grants and latency.
    gnt_rand = 1'b1;
    for (int it = 0; it < 12; it++) begin
      lat = $urandom_range(1, 6);
      load(32'h8000 + 32'($urandom_range(0, 4095)), 32'h8000 + 32'($urandom_range(0, 4095)) + 32'($urandom_range(0, 72)));
      rand_reads(8);
    end

    // Frame counter wrap.
    fc_mode = 2;
    repeat (300) @(posedge clk);
    fc_mode = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("rd_queue_empty", exp_rd_q.size(), 32'h0);
    chk("start_queue_empty", exp_start_q.size(), 32'h0);
    chk("addr_queue_empty", exp_addr_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
